// File: rtl/wash_panel.sv
// Front-panel controller for washing_machine: debounces coin/double/pause buttons and sequences a wash.
// Optional watchdog with FAULT state is compiled in by defining PANEL_WDOG_EN.
module wash_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned DONE_HOLD       = 8,
    parameter int unsigned WDOG_CYCLES     = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic coin_btn,
    input  logic dbl_btn,
    input  logic pause_btn,
    input  logic wash_done,
    output logic coin_in,
    output logic double_wash,
    output logic timer_pause,
    output logic busy,
    output logic dbl_led,
    output logic done_led,
    output logic fault
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
    localparam int unsigned N_BTN  = 3;
    localparam int unsigned BTN_COIN  = 0;
    localparam int unsigned BTN_DBL   = 1;
    localparam int unsigned BTN_PAUSE = 2;

`ifdef PANEL_WDOG_EN
    localparam int unsigned WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t state, state_nxt;

    logic [N_BTN-1:0] raw, sync1, sync2, deb, deb_q, press;
    logic [DB_W-1:0]  db_cnt [N_BTN];
    logic             done_q, done_rise;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic coin_nxt, dw_nxt, tp_nxt, dbl_sel_nxt, busy_nxt, done_led_nxt;

    assign raw       = {pause_btn, dbl_btn, coin_btn};
    assign press     = deb & ~deb_q;
    assign done_rise = wash_done & ~done_q;

    // Synchronize, then accept a new level only after DEBOUNCE_CYCLES differing cycles in a row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < int'(N_BTN); i++) db_cnt[i] <= '0;
        end else begin
            sync1  <= raw;
            sync2  <= sync1;
            deb_q  <= deb;
            done_q <= wash_done;
            for (int i = 0; i < int'(N_BTN); i++) begin
                if (sync2[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        deb[i]    <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

`ifdef PANEL_WDOG_EN
    logic [WD_W-1:0] wdog_cnt, wdog_nxt;
    logic            fault_nxt;
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            coin_in     <= 1'b0;
            double_wash <= 1'b0;
            timer_pause <= 1'b0;
            busy        <= 1'b0;
            dbl_led     <= 1'b0;
            done_led    <= 1'b0;
`ifdef PANEL_WDOG_EN
            wdog_cnt    <= '0;
            fault       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            coin_in     <= coin_nxt;
            double_wash <= dw_nxt;
            timer_pause <= tp_nxt;
            busy        <= busy_nxt;
            dbl_led     <= dbl_sel_nxt;
            done_led    <= done_led_nxt;
`ifdef PANEL_WDOG_EN
            wdog_cnt    <= wdog_nxt;
            fault       <= fault_nxt;
`endif
        end
    end

    // Next state and next output values; wash_done beats pause and watchdog.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold_cnt;
        coin_nxt    = coin_in;
        dw_nxt      = double_wash;
        tp_nxt      = timer_pause;
        dbl_sel_nxt = dbl_led;
`ifdef PANEL_WDOG_EN
        wdog_nxt    = wdog_cnt;
`endif
        case (state)
            IDLE: begin
                hold_nxt = '0;
`ifdef PANEL_WDOG_EN
                wdog_nxt = '0;
`endif
                if (press[BTN_DBL]) dbl_sel_nxt = ~dbl_led;
                if (press[BTN_COIN]) begin
                    state_nxt = RUN;
                    coin_nxt  = 1'b1;
                    dw_nxt    = dbl_sel_nxt;
                    tp_nxt    = 1'b0;
                end
            end
            RUN: begin
                if (done_rise) begin
                    state_nxt = DONE;
                    hold_nxt  = '0;
                    coin_nxt  = 1'b0;
                    dw_nxt    = 1'b0;
                    tp_nxt    = 1'b0;
                end else begin
                    if (press[BTN_PAUSE]) tp_nxt = ~timer_pause;
`ifdef PANEL_WDOG_EN
                    if (!timer_pause) begin
                        if (wdog_cnt == WD_W'(WDOG_CYCLES - 1)) begin
                            state_nxt = FAULT;
                            coin_nxt  = 1'b0;
                            dw_nxt    = 1'b0;
                            tp_nxt    = 1'b0;
                        end else begin
                            wdog_nxt = wdog_cnt + 1'b1;
                        end
                    end
`endif
                end
            end
            DONE: begin
                if (hold_cnt == HOLD_W'(DONE_HOLD - 1)) begin
                    state_nxt = IDLE;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
        busy_nxt     = (state_nxt == RUN) || (state_nxt == DONE);
        done_led_nxt = (state_nxt == DONE);
`ifdef PANEL_WDOG_EN
        fault_nxt    = (state_nxt == FAULT);
`endif
    end

`ifndef PANEL_WDOG_EN
    assign fault = 1'b0;
`endif

endmodule

// File: doc/wash_panel.md
# wash_panel

Front-panel controller that sits on the user side of `washing_machine`. It debounces the raw coin, double-wash and pause buttons, then drives the machine's `coin_in`, `double_wash` and `timer_pause` inputs through a wash cycle. It consumes the machine's `wash_done` to close the cycle and re-arm for the next customer. It shares the machine's clock and reset.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required before a synchronized button level is accepted (≥2).
- `DONE_HOLD`, 8: cycles spent in DONE before returning to IDLE (≥1).
- `WDOG_CYCLES`, 4096: unpaused RUN cycles allowed before fault (used only with `PANEL_WDOG_EN`).

- `clk` in 1: system clock, shared with `washing_machine`.
- `rst_n` in 1: asynchronous active-low reset.
- `coin_btn` in 1: raw coin-acceptor contact, asynchronous.
- `dbl_btn` in 1: raw double-wash button, asynchronous.
- `pause_btn` in 1: raw pause button, asynchronous.
- `wash_done` in 1: from `washing_machine`, synchronous to `clk`.
- `coin_in` out 1: to machine; high for the whole RUN state.
- `double_wash` out 1: to machine; selection latched at cycle start.
- `timer_pause` out 1: to machine; pause toggle, valid only in RUN.
- `busy` out 1: high in RUN or DONE.
- `dbl_led` out 1: current double-wash selection.
- `done_led` out 1: high in DONE.
- `fault` out 1: watchdog fault; tied 0 without `PANEL_WDOG_EN`.

## Operation
- Each button path: 2-flop synchronizer, then a debounce counter.
  - While the synchronized level differs from the debounced level, the counter increments. Any cycle in which they match clears it.
  - After `DEBOUNCE_CYCLES` consecutive differing cycles, the debounced level updates.
  - A debounced 0→1 transition produces a one-cycle press event. Releases produce no event.
- `wash_done` rising edge is detected against a registered copy. It is not synchronized.
- FSM states: IDLE, RUN, DONE, plus FAULT when the watchdog is compiled in.
  - IDLE: a dbl press toggles `dbl_sel`. A coin press moves to RUN; `coin_in`←1 and `double_wash`←`dbl_sel` (after any same-cycle toggle).
  - RUN: a pause press toggles `timer_pause`. Coin and dbl presses are ignored. A `wash_done` rising edge moves to DONE; `coin_in`, `timer_pause` and `double_wash`←0.
  - DONE: the hold counter counts `DONE_HOLD` cycles, then the FSM goes to IDLE. All presses are ignored; `dbl_sel` is retained.
- Simultaneous events in RUN: a `wash_done` edge and a pause press together → done wins and `timer_pause` ends at 0.
- If `wash_done` is already high on entry to RUN, no edge is seen; RUN waits for a fresh rising edge.
- Reset (at any time, including mid-RUN): all state, counters and outputs go to 0 asynchronously; the FSM goes to IDLE and `dbl_sel`=0.

## Timing
- All outputs are registered; reset value of every output is 0.
- Raw press to press event: the raw level must be stable for 2 sync cycles plus `DEBOUNCE_CYCLES`.
  - The event is asserted in cycle 2+`DEBOUNCE_CYCLES` after the first edge that samples the new raw level.
  - The resulting output change is visible one edge later.
- `wash_done` edge at edge N → `coin_in` low and `done_led` high after edge N+1.
- `done_led` is high for exactly `DONE_HOLD` cycles; `busy` drops on the same edge.
- A bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no event.

## Configuration
- `PANEL_WDOG_EN` defined:
  - The watchdog counter increments in RUN on cycles with `timer_pause`=0, holds while paused, and clears on entry to RUN.
  - When it reaches `WDOG_CYCLES` with no `wash_done` edge, the FSM enters FAULT: `coin_in`, `double_wash`, `timer_pause` and `busy`←0, `fault`←1.
  - FAULT is exited only by reset.
  - If a `wash_done` edge occurs on the same cycle the count is reached, done wins.
- `PANEL_WDOG_EN` undefined: no watchdog logic, no FAULT state, `fault` is constant 0.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `DONE_HOLD`=8.
- Basic cycle: coin held 10 cycles → `coin_in`=1 and `double_wash`=0 at raw-edge+7. `wash_done` pulse → `coin_in`=0 next edge. `done_led` high 8 cycles, then IDLE.
- Double wash: dbl press then coin press → `dbl_led`=1 and `double_wash`=1 throughout RUN. A second dbl press during RUN leaves `dbl_led`=1.
- Bounce rejection: coin toggled every 2 cycles for 20 cycles, then low → `coin_in` stays 0. A 3-cycle clean pulse is also rejected.
- Pause: in RUN, pause press → `timer_pause`=1; second press → 0. A pause press coincident with a `wash_done` edge → `timer_pause`=0 and the FSM enters DONE.
- Reset mid-RUN: drop `rst_n` with `coin_in`=1 and `timer_pause`=1 → all outputs 0 immediately, without a clock edge; a later coin press starts a new cycle.
- With `PANEL_WDOG_EN` and `WDOG_CYCLES`=50: RUN with no `wash_done` and 20 paused cycles → `fault`=1 at 50 unpaused cycles, `coin_in`=0; only `rst_n` clears it.
